// File: rtl/spram_arb_pkg.sv
// Shared types for the two-port single-port-RAM arbiter.
package spram_arb_pkg;

  localparam int NPORTS = 2;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie, the port that was not granted last wins.
module rr_arb2
  import spram_arb_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic              last,
  output logic [NPORTS-1:0] gnt
);

  // last=1 means port 1 was granted most recently, so port 0 has priority.
  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/spram_arbiter.sv
// Arbitrates two requesters onto one single-port RAM, one access per cycle.
// Optional macro SPRAM_ARB_RANGE_CHK_EN enables out-of-range / misaligned error responses.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter  int SIZE = 'h10000,
  localparam int AW   = $clog2(SIZE) - 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic [3:0]    p0_we,
  input  logic [31:0]   p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic [3:0]    p1_we,
  input  logic [31:0]   p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_rdata,
  output logic          p1_err,
  output logic          ram_ce,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_d,
  input  logic [31:0]   ram_q
);

  req_t              req_in [NPORTS];
  rsp_t              rsp_out [NPORTS];
  logic [NPORTS-1:0] req_vec;
  logic [NPORTS-1:0] arb_gnt;
  logic [NPORTS-1:0] gnt;
  req_t              sel;
  logic              bad;
  logic              last;
  logic              rsp_valid;
  logic              rsp_owner;
  logic              rsp_read;
  logic              rsp_err;

  assign req_in[0] = {p0_we, p0_addr, p0_wdata};
  assign req_in[1] = {p1_we, p1_addr, p1_wdata};
  assign req_vec   = {p1_req, p0_req};

  rr_arb2 u_arb (
    .req  (req_vec),
    .last (last),
    .gnt  (arb_gnt)
  );

  // Grants are suppressed while reset is held so nothing reaches the RAM.
  assign gnt = arb_gnt & {NPORTS{rst_n}};
  assign sel = gnt[1] ? req_in[1] : req_in[0];

`ifdef SPRAM_ARB_RANGE_CHK_EN
  assign bad = (sel.addr >= 32'(SIZE)) || (sel.addr[1:0] != 2'b00);
`else
  logic unused_addr_bits;
  assign bad              = 1'b0;
  assign unused_addr_bits = ^{sel.addr[31:AW+2], sel.addr[1:0]};
`endif

  assign ram_ce   = (|gnt) & ~bad;
  assign ram_we   = ram_ce ? sel.we : 4'b0000;
  assign ram_addr = sel.addr[AW+1:2];
  assign ram_d    = sel.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_owner <= 1'b0;
      rsp_read  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= |gnt;
      if (|gnt) begin
        last      <= gnt[1];
        rsp_owner <= gnt[1];
        rsp_read  <= (sel.we == 4'b0000);
        rsp_err   <= bad;
      end
    end
  end

  // Response fields are forced to zero on the port that does not own the response.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      rsp_out[i] = '0;
      if (rsp_valid && (rsp_owner == 1'(i))) begin
        rsp_out[i].rvalid = 1'b1;
        rsp_out[i].err    = rsp_err;
        rsp_out[i].rdata  = (rsp_read && !rsp_err) ? ram_q : 32'h0;
      end
    end
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rsp_out[0].rvalid;
  assign p0_rdata  = rsp_out[0].rdata;
  assign p0_err    = rsp_out[0].err;
  assign p1_rvalid = rsp_out[1].rvalid;
  assign p1_rdata  = rsp_out[1].rdata;
  assign p1_err    = rsp_out[1].err;

endmodule

// File: tb/tb_spram_arbiter.sv
// Scoreboard bench for spram_arbiter with a behavioural RAM; honours SPRAM_ARB_RANGE_CHK_EN.
module tb_spram_arbiter;
  import spram_arb_pkg::*;

  localparam int SIZE = 'h10000;
  localparam int AW   = $clog2(SIZE) - 2;
  localparam int W    = 33;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req, p1_req;
  logic [3:0]    p0_we, p1_we;
  logic [31:0]   p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
  logic [31:0]   p0_rdata, p1_rdata;
  logic          ram_ce;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_d, ram_q;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic [W-1:0]  exp_q0[$];
  logic [W-1:0]  exp_q1[$];
  int            n_checks = 0;
  int            n_fail = 0;

  spram_arbiter #(.SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural single-port RAM, read data one cycle after ce
  always @(posedge clk) begin
    if (ram_ce) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
      ram_q <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: pops on every rvalid, expects zeros otherwise
  task automatic mon(input int p, input logic v, input logic [31:0] d, input logic e);
    logic [W-1:0] exp;
    int           depth;
    if (v) begin
      depth = (p == 0) ? exp_q0.size() : exp_q1.size();
      if (depth == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rvalid_p%0d: got rvalid=1 expected no response at %0t", p, $time);
      end else begin
        exp = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk($sformatf("rsp_p%0d", p), {31'b0, e, d}, {31'b0, exp});
      end
    end else begin
      chk($sformatf("idle_zero_p%0d", p), {31'b0, e, d}, 64'h0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, p0_rvalid, p0_rdata, p0_err);
      mon(1, p1_rvalid, p1_rdata, p1_err);
    end
  end

  // driver tasks
  task automatic set_req(input int p, input logic r, input logic [3:0] we,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      p0_req = r; p0_we = we; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = r; p1_we = we; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic push(input int p, input logic [W-1:0] e);
    if (p == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // One-cycle request from a lone port; entered and left at posedge+1.
  task automatic single(input int p, input logic [3:0] we, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_ce, input logic [W-1:0] exp);
    set_req(p, 1'b1, we, a, d);
    @(negedge clk);
    chk("gnt_p0", 64'(p0_gnt), 64'(p == 0));
    chk("gnt_p1", 64'(p1_gnt), 64'(p == 1));
    chk("ram_ce", 64'(ram_ce), 64'(exp_ce));
    if (exp_ce) begin
      chk("ram_we", 64'(ram_we), 64'(we));
      chk("ram_addr", 64'(ram_addr), 64'(a[AW+1:2]));
      if (we != 4'b0) chk("ram_d", 64'(ram_d), 64'(d));
    end else begin
      chk("ram_we_off", 64'(ram_we), 64'h0);
    end
    push(p, exp);
    @(posedge clk); #1;
    set_req(p, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    set_req(0, 1'b1, 4'hF, 32'h10, 32'h1);
    set_req(1, 1'b1, 4'hF, 32'h20, 32'h2);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt",    64'({p1_gnt, p0_gnt}), 64'h0);
    chk("rst_rvalid", 64'({p1_rvalid, p0_rvalid}), 64'h0);
    chk("rst_err",    64'({p1_err, p0_err}), 64'h0);
    chk("rst_ram_ce", 64'(ram_ce), 64'h0);
    chk("rst_ram_we", 64'(ram_we), 64'h0);
    set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // write then read back on port 0
    single(0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b1, 33'h0);
    single(0, 4'h0, 32'h10, 32'h0, 1'b1, {1'b0, 32'hDEADBEEF});

    // byte-lane write on port 1
    single(1, 4'hF, 32'h20, 32'h11223344, 1'b1, 33'h0);
    single(1, 4'b0010, 32'h20, 32'h0000AB00, 1'b1, 33'h0);
    single(1, 4'h0, 32'h20, 32'h0, 1'b1, {1'b0, 32'h1122AB44});

    // port 1 alone: back-to-back writes then reads, rvalid every cycle
    for (int i = 0; i < 8; i++)
      single(1, 4'hF, 32'h100 + 32'(4*i), 32'hC0DE0000 + 32'(i), 1'b1, 33'h0);
    for (int i = 0; i < 8; i++) begin
      set_req(1, 1'b1, 4'h0, 32'h100 + 32'(4*i), 32'h0);
      @(negedge clk);
      chk("b2b_gnt", 64'(p1_gnt), 64'h1);
      chk("b2b_rvalid", 64'(p1_rvalid), 64'h1);
      push(1, {1'b0, 32'hC0DE0000 + 32'(i)});
      @(posedge clk); #1;
    end
    set_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("b2b_last_rvalid", 64'(p1_rvalid), 64'h1);
    @(posedge clk); #1;

    // range / alignment handling
    single(0, 4'hF, 32'h0, 32'hA5A5A5A5, 1'b1, 33'h0);
    single(0, 4'hF, 32'h4, 32'h0BADF00D, 1'b1, 33'h0);
`ifdef SPRAM_ARB_RANGE_CHK_EN
    single(0, 4'h0, 32'(SIZE), 32'h0, 1'b0, {1'b1, 32'h0});
    single(0, 4'h0, 32'h6, 32'h0, 1'b0, {1'b1, 32'h0});
`else
    single(0, 4'h0, 32'(SIZE), 32'h0, 1'b1, {1'b0, 32'hA5A5A5A5});
    single(0, 4'h0, 32'h6, 32'h0, 1'b1, {1'b0, 32'h0BADF00D});
`endif
    repeat (2) @(posedge clk);
    #1;

    // reset right after a read grant discards its response
    set_req(0, 1'b1, 4'h0, 32'h10, 32'h0);
    @(negedge clk);
    chk("rst_mid_gnt", 64'(p0_gnt), 64'h1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_ram_ce", 64'(ram_ce), 64'h0);
    chk("rst_mid_rvalid", 64'(p0_rvalid), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_rvalid_after_rst", 64'(p0_rvalid), 64'h0);
    end
    @(posedge clk); #1;

    // both ports requesting from reset: alternate starting at port 0
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(0, 1'b1, 4'h0, 32'h10, 32'h0);
    set_req(1, 1'b1, 4'h0, 32'h20, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rr_gnt_p0", 64'(p0_gnt), 64'(c % 2 == 0));
      chk("rr_gnt_p1", 64'(p1_gnt), 64'(c % 2 == 1));
      chk("rr_ram_ce", 64'(ram_ce), 64'h1);
      if (c > 0) chk("rr_rvalid", 64'({p1_rvalid, p0_rvalid}), (c % 2 == 1) ? 64'h1 : 64'h2);
      if (c % 2 == 0) push(0, {1'b0, 32'hDEADBEEF});
      else            push(1, {1'b0, 32'h1122AB44});
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_req(1, 1'b0, 4'h0, 32'h0, 32'h0);

    for (int k = 0; k < 10 && (exp_q0.size() + exp_q1.size()) > 0; k++)
      @(posedge clk);
    @(posedge clk); #1;
    chk("drain", 64'(exp_q0.size() + exp_q1.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spram_arbiter.md
SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 SIZE, 'h10000, RAM size in bytes; SHALL be a power of two and at least 8.
REQ-002 AW, $clog2(SIZE)-2, RAM word-address width; SHALL be derived from SIZE and never overridden.
REQ-003 clk  input  1  single clock; all state SHALL be updated on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 pN_req  input  1  request from requester N (N = 0, 1); SHALL stay high, with its pN_we/pN_addr/pN_wdata stable, until pN_gnt.
REQ-006 pN_we  input  4  byte write enables; all zero means a read.
REQ-007 pN_addr  input  32  byte address.
REQ-008 pN_wdata  input  32  write data.
REQ-009 pN_gnt  output  1  request accepted this cycle.
REQ-010 pN_rvalid  output  1  response strobe.
REQ-011 pN_rdata  output  32  read data.
REQ-012 pN_err  output  1  error response, qualified by pN_rvalid.
REQ-013 ram_ce  output  1  RAM chip enable.
REQ-014 ram_we  output  4  RAM byte write enables.
REQ-015 ram_addr  output  AW  RAM word address.
REQ-016 ram_d  output  32  RAM write data.
REQ-017 ram_q  input  32  RAM read data, valid one cycle after ram_ce.

Function
REQ-018 The block SHALL issue at most one grant per cycle; pN_gnt SHALL be combinational from pN_req and the round-robin pointer, with zero-cycle latency.
REQ-019 With a single requester, that requester SHALL be granted every cycle it requests, with no bubbles between back-to-back grants.
REQ-020 With both requesting, the port other than the last-granted port SHALL win; the last-granted register SHALL update only on a grant.
REQ-021 In a grant cycle: ram_ce=1, ram_we=pN_we, ram_addr=pN_addr[AW+1:2], ram_d=pN_wdata; in any other cycle: ram_ce=0 and ram_we=0.
REQ-022 Exactly one cycle after each grant, pN_rvalid SHALL pulse for exactly one cycle on the granted port only, for both reads and writes.
REQ-023 Read response: pN_rdata=ram_q. Write response: pN_rdata=0.
REQ-024 pN_rdata and pN_err SHALL be 0 whenever pN_rvalid=0.
REQ-025 A grant in the same cycle as an rvalid SHALL be legal, giving full throughput of one access per cycle.

Reset
REQ-026 While rst_n=0: all pN_gnt, pN_rvalid, pN_err and ram_ce SHALL be 0, ram_we SHALL be 0, and last-granted SHALL be 1, so that port 0 wins the first tie.
REQ-027 Reset asserted mid-operation SHALL discard any pending response; no rvalid SHALL follow reset release without a new grant.

Configuration
REQ-028 Macro SPRAM_ARB_RANGE_CHK_EN defined: a granted access with pN_addr >= SIZE or pN_addr[1:0] != 0 SHALL keep ram_ce=0 and SHALL respond one cycle later with rvalid=1, err=1, rdata=0.
REQ-029 Macro SPRAM_ARB_RANGE_CHK_EN undefined: pN_err SHALL be tied 0, pN_addr bits above AW+1 and bits [1:0] SHALL be ignored, and addresses SHALL wrap modulo SIZE.

Structure
REQ-030 Package spram_arb_pkg SHALL hold NPORTS=2, a request struct (we, addr, wdata) and a response struct (rvalid, rdata, err).
REQ-031 The two-way round-robin picker SHALL be a sub-module named rr_arb2, with inputs req[1:0] and last and output gnt[1:0].
REQ-032 The response path SHALL consist of a registered valid bit, owner bit, is-read bit and err bit.

Verification
REQ-033 Stimulus: p0 write we=4'hF, addr=0x10, data=0xDEADBEEF, then p0 read addr=0x10. Response: gnt same cycle as req, rvalid +1 cycle, rdata=0xDEADBEEF.
REQ-034 Stimulus: p0 and p1 both request continuously for 6 cycles from reset. Response: grants alternate 0,1,0,1,0,1 and rvalid goes to the matching port each cycle.
REQ-035 Stimulus: p1 writes we=4'b0010, data=0x0000AB00 to a word holding 0x11223344, then reads it. Response: rdata=0x1122AB44.
REQ-036 Stimulus: p0 read with rst_n pulsed low in the cycle after gnt. Response: no p0_rvalid, and ram_ce=0 during reset.
REQ-037 Stimulus (SPRAM_ARB_RANGE_CHK_EN defined): read addr=SIZE, then read addr=0x6. Response: ram_ce=0, err=1, rdata=0 for both; an undefined build instead reads word 0 and word 1.
REQ-038 Stimulus: p1 alone issues 8 back-to-back reads. Response: 8 consecutive gnt cycles and 8 consecutive rvalid cycles, with no idle cycles.
